led_pattern_ctrl: RTL and testbench

- Parametrised successor to the free-running LED blinker.
- Drives NUM_LEDS board LEDs. Each channel is independently configured as OFF, ON-with-PWM-dimming, BLINK or BREATHE.
- Timing derives from one internal prescaler instead of fixed counter taps.
- Sits at board top level between a simple config write port (host or test logic) and the LED pins.

---
 rtl/led_pattern_ctrl.sv | 111 +++++++++++
 tb/tb_led_pattern_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_ctrl.sv
// rtl/led_pattern_ctrl.sv - multi-channel LED driver with OFF/ON/BLINK/BREATHE modes
// Shared prescaler, PWM counter and blink phase; per-channel mode, duty and breathe level.
module led_pattern_ctrl #(
  parameter int NUM_LEDS    = 5,
  parameter int PRESCALE    = 262144,
  parameter int PWM_W       = 8,
  parameter int BLINK_TICKS = 4
) (
  input  logic                hwclk,
  input  logic                rst_n,
  input  logic                cfg_we,
  input  logic [3:0]          cfg_addr,
  input  logic [1:0]          cfg_mode,
  input  logic [PWM_W-1:0]    cfg_duty,
  output logic [NUM_LEDS-1:0] leds,
  output logic                tick
);

  localparam int PRE_W = $clog2(PRESCALE);
  localparam int BLK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX   = PRE_W'(PRESCALE - 1);
  localparam logic [BLK_W-1:0] BLINK_MAX = BLK_W'(BLINK_TICKS - 1);
  localparam logic [PWM_W-1:0] LEVEL_MAX = '1;

  localparam logic [1:0] MODE_OFF     = 2'd0;
  localparam logic [1:0] MODE_ON      = 2'd1;
  localparam logic [1:0] MODE_BLINK   = 2'd2;
  localparam logic [1:0] MODE_BREATHE = 2'd3;

  logic [PRE_W-1:0]    pre_cnt;
  logic [PWM_W-1:0]    pwm_cnt;
  logic [BLK_W-1:0]    blink_cnt;
  logic                blink_phase;
  logic [1:0]          mode_q  [NUM_LEDS];
  logic [PWM_W-1:0]    duty_q  [NUM_LEDS];
  logic [PWM_W-1:0]    level_q [NUM_LEDS];
  logic [NUM_LEDS-1:0] down_q;
  logic [NUM_LEDS-1:0] led_next;

  // Shared timebase: prescaler, registered tick, free-running PWM counter, blink phase.
  always_ff @(posedge hwclk) begin
    if (!rst_n) begin
      pre_cnt     <= '0;
      tick        <= 1'b0;
      pwm_cnt     <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      pre_cnt <= (pre_cnt == PRE_MAX) ? '0 : pre_cnt + 1'b1;
      tick    <= (pre_cnt == PRE_MAX);
      pwm_cnt <= pwm_cnt + 1'b1;
      if (tick) begin
        if (blink_cnt == BLINK_MAX) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end
    end
  end

  // A write to a channel takes priority over its breathe step on the same tick.
  always_ff @(posedge hwclk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_LEDS; i++) begin
        mode_q[i]  <= MODE_OFF;
        duty_q[i]  <= '0;
        level_q[i] <= '0;
        down_q[i]  <= 1'b0;
      end
    end else begin
      for (int i = 0; i < NUM_LEDS; i++) begin
        if (cfg_we && (cfg_addr == 4'(i))) begin
          mode_q[i] <= cfg_mode;
          duty_q[i] <= cfg_duty;
          if (cfg_mode == MODE_BREATHE) begin
            level_q[i] <= '0;
            down_q[i]  <= 1'b0;
          end
        end else if (tick && (mode_q[i] == MODE_BREATHE)) begin
          if (!down_q[i]) begin
            if (level_q[i] == LEVEL_MAX) down_q[i] <= 1'b1;
            else                         level_q[i] <= level_q[i] + 1'b1;
          end else begin
            if (level_q[i] == '0) down_q[i] <= 1'b0;
            else                  level_q[i] <= level_q[i] - 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    led_next = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      case (mode_q[i])
        MODE_ON:      led_next[i] = (pwm_cnt < duty_q[i]);
        MODE_BLINK:   led_next[i] = blink_phase & (pwm_cnt < duty_q[i]);
        MODE_BREATHE: led_next[i] = (pwm_cnt < level_q[i]);
        default:      led_next[i] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge hwclk) begin
    if (!rst_n) leds <= '0;
    else        leds <= led_next;
  end

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// tb/tb_led_pattern_ctrl.sv - randomized and directed bench for led_pattern_ctrl
// Reference model derives all timing from the edge count since reset.
module tb_led_pattern_ctrl;

  localparam int NL = 5;
  localparam int P  = 4;
  localparam int W  = 3;
  localparam int B  = 2;
  localparam int PW = 1 << W;

  logic          hwclk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_we = 1'b0;
  logic [3:0]    cfg_addr = '0;
  logic [1:0]    cfg_mode = '0;
  logic [W-1:0]  cfg_duty = '0;
  logic [NL-1:0] leds;
  logic          tick;

  int checks = 0;
  int errors = 0;

  led_pattern_ctrl #(.NUM_LEDS(NL), .PRESCALE(P), .PWM_W(W), .BLINK_TICKS(B)) dut (
    .hwclk(hwclk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_mode(cfg_mode), .cfg_duty(cfg_duty), .leds(leds), .tick(tick)
  );

  always #5 hwclk = ~hwclk;

  // Ticks consumed by the first n edges after reset: tick is high after edges P, 2P, ...
  function automatic int ticks_by(int n);
    return (n < 1) ? 0 : (n - 1) / P;
  endfunction

  // Breathe level t ticks after a restart: 0..PW-1, PW-1..0, repeating.
  function automatic int pat(int t);
    int j;
    j = t % (2 * PW);
    return (j < PW) ? j : (2 * PW - 1 - j);
  endfunction

  int m_mode [NL];
  int m_duty [NL];
  int m_start[NL];
  int n = 0;

  initial begin
    logic s_rst, s_we;
    int s_addr, s_mode, s_duty, pc, ph;
    logic [NL-1:0] exp_leds;
    logic exp_tick;
    forever begin
      @(posedge hwclk);
      s_rst = rst_n; s_we = cfg_we; s_addr = cfg_addr; s_mode = cfg_mode; s_duty = cfg_duty;
      @(negedge hwclk);
      exp_leds = '0;
      if (!s_rst) begin
        n = 0;
        for (int i = 0; i < NL; i++) begin m_mode[i] = 0; m_duty[i] = 0; m_start[i] = 0; end
      end else begin
        pc = n % PW;
        ph = (ticks_by(n) / B) % 2;
        for (int i = 0; i < NL; i++) begin
          case (m_mode[i])
            1: exp_leds[i] = (pc < m_duty[i]);
            2: exp_leds[i] = (ph == 1) && (pc < m_duty[i]);
            3: exp_leds[i] = (pc < pat(ticks_by(n) - m_start[i]));
            default: exp_leds[i] = 1'b0;
          endcase
        end
        n++;
        if (s_we && s_addr < NL) begin
          m_mode[s_addr] = s_mode;
          m_duty[s_addr] = s_duty;
          if (s_mode == 3) m_start[s_addr] = ticks_by(n);
        end
      end
      exp_tick = s_rst && (n >= P) && (n % P == 0);
      checks++;
      if (leds !== exp_leds) begin
        errors++;
        $display("FAIL leds n=%0d got %b expected %b", n, leds, exp_leds);
      end
      checks++;
      if (tick !== exp_tick) begin
        errors++;
        $display("FAIL tick n=%0d got %b expected %b", n, tick, exp_tick);
      end
    end
  end

  task automatic cyc(input int k);
    repeat (k) @(posedge hwclk);
    #1;
  endtask

  task automatic wr(input int a, input int m, input int d);
    cfg_we = 1'b1; cfg_addr = 4'(a); cfg_mode = 2'(m); cfg_duty = W'(d);
    cyc(1);
    cfg_we = 1'b0;
  endtask

  task automatic lit(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic count_high(input int ch, input int len, output int c);
    c = 0;
    repeat (len) begin @(negedge hwclk); c += int'(leds[ch]); end
    @(posedge hwclk); #1;
  endtask

  initial begin
    int k, c;
    int duties[3] = '{0, 3, 7};
    cyc(3);
    lit("reset_leds", int'(leds), 0);
    lit("reset_tick", int'(tick), 0);
    rst_n = 1'b1;
    k = 0;
    for (int i = 1; i <= 20; i++) begin
      cyc(1);
      if (tick) begin k = i; break; end
    end
    lit("first_tick_delay", k, 4);
    cyc(4);
    lit("tick_period", int'(tick), 1);

    foreach (duties[j]) begin
      wr(0, 1, duties[j]);
      cyc(2);
      count_high(0, 8, c);
      lit("on_duty_count", c, duties[j]);
    end

    wr(1, 2, 7);
    cyc(20);
    count_high(1, 16, c);
    lit("blink_count", c, 7);
    wr(2, 2, 7);
    cyc(3);
    c = 0;
    repeat (16) begin @(negedge hwclk); c += int'(leds[1] != leds[2]); end
    cyc(1);
    lit("blink_aligned", c, 0);

    wr(3, 3, 0);
    cyc(90);
    wr(3, 3, 5);
    cyc(20);

    wr(7, 1, 5);
    cyc(8);

    k = 0;
    for (int i = 0; i < 10; i++) begin
      if (tick) begin k = 1; break; end
      cyc(1);
    end
    lit("found_tick", k, 1);
    wr(4, 3, 0);
    cyc(40);

    for (int i = 0; i < 400; i++) begin
      rst_n    = ($urandom_range(0, 99) != 0);
      cfg_we   = ($urandom_range(0, 3) == 0);
      cfg_addr = 4'($urandom_range(0, 7));
      cfg_mode = 2'($urandom_range(0, 3));
      cfg_duty = W'($urandom_range(0, PW - 1));
      cyc(1);
    end
    rst_n = 1'b1; cfg_we = 1'b0;
    cyc(20);

    rst_n = 1'b0; cfg_we = 1'b1; cfg_addr = 4'd0; cfg_mode = 2'd1; cfg_duty = W'(7);
    cyc(1);
    lit("rst_write_leds", int'(leds), 0);
    lit("rst_write_tick", int'(tick), 0);
    rst_n = 1'b1; cfg_we = 1'b0;
    cyc(12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
